// File: rtl/srt_div_sequencer.sv
// ---------------------------------------------------------------------------
// srt_div_sequencer
//
// Control and handshake wrapper for the FP32 radix-4 SRT divider datapath.
// It accepts one operand pair on a valid/ready handshake and screens it for
// IEEE-754 special cases. Those are answered directly with a canned result.
// Ordinary pairs are handed to the datapath: one load strobe, then exactly
// ITERATIONS radix-4 steps, then one settle cycle. After that the
// post-processed quotient is captured and held until the consumer takes it.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid / in_ready      operand handshake; ready only while idle
//   dividend, divisor        FP32 operands
//   dp_dividend, dp_divisor  registered operands presented to the datapath
//   dp_load                  one-cycle datapath initialisation strobe
//   dp_iter_en               datapath performs one radix-4 step this cycle
//   dp_quotient              post-processed quotient from the datapath
//   out_valid / out_ready    result handshake
//   quotient                 registered result
//   div_by_zero, invalid     result flags, qualified by out_valid
//   busy                     sequencer is not idle
// ---------------------------------------------------------------------------
module srt_div_sequencer #(
  parameter int ITERATIONS = 13,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] dp_dividend,
  output logic [31:0] dp_divisor,
  output logic        dp_load,
  output logic        dp_iter_en,
  input  logic [31:0] dp_quotient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    POST,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       dp_dividend_q;
  logic [31:0]       dp_divisor_q;
  logic              dp_load_q;
  logic              dp_iter_en_q;
  logic [31:0]       quotient_q;
  logic              out_valid_q;
  logic              div_by_zero_q;
  logic              invalid_q;

  // Operand field decode for classification
  logic       a_exp_max, b_exp_max, a_exp_zero, b_exp_zero;
  logic       a_man_zero, b_man_zero;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic       sign_x;

  assign a_exp_max  = (dividend[30:23] == 8'hFF);
  assign b_exp_max  = (divisor[30:23]  == 8'hFF);
  assign a_exp_zero = (dividend[30:23] == 8'h00);
  assign b_exp_zero = (divisor[30:23]  == 8'h00);
  assign a_man_zero = (dividend[22:0]  == 23'h0);
  assign b_man_zero = (divisor[22:0]   == 23'h0);
  assign a_nan      = a_exp_max  & ~a_man_zero;
  assign b_nan      = b_exp_max  & ~b_man_zero;
  assign a_inf      = a_exp_max  &  a_man_zero;
  assign b_inf      = b_exp_max  &  b_man_zero;
  // Subnormals are deliberately not zero: the normalizer handles them
  assign a_zero     = a_exp_zero &  a_man_zero;
  assign b_zero     = b_exp_zero &  b_man_zero;
  assign sign_x     = dividend[31] ^ divisor[31];

  logic        special_d;
  logic [31:0] spec_quotient_d;
  logic        spec_dbz_d;
  logic        spec_inv_d;

  // Special-case screening in priority order. Each branch relies on the
  // earlier ones having removed NaNs, 0/0 and inf/inf, so e.g. "aInf" in the
  // third branch implies a finite divisor (which includes inf/0).
  always_comb begin
    special_d       = 1'b1;
    spec_quotient_d = 32'h0;
    spec_dbz_d      = 1'b0;
    spec_inv_d      = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_quotient_d = 32'h7FC0_0000;
      spec_inv_d      = 1'b1;
    end else if (!a_inf && !a_zero && b_zero) begin
      spec_quotient_d = {sign_x, 8'hFF, 23'h0};
      spec_dbz_d      = 1'b1;
    end else if (a_inf) begin
      spec_quotient_d = {sign_x, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      spec_quotient_d = {sign_x, 31'h0};
    end else begin
      special_d       = 1'b0;
    end
  end

  // Sequencer FSM with all datapath strobes and result fields registered.
  // The counter holds at ITERATIONS-1 on the way out of ITER so it can
  // never wrap, and is re-zeroed in LOAD for the next divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dp_dividend_q <= 32'h0;
      dp_divisor_q  <= 32'h0;
      dp_load_q     <= 1'b0;
      dp_iter_en_q  <= 1'b0;
      quotient_q    <= 32'h0;
      out_valid_q   <= 1'b0;
      div_by_zero_q <= 1'b0;
      invalid_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dp_dividend_q <= dividend;
            dp_divisor_q  <= divisor;
            if (special_d) begin
              quotient_q    <= spec_quotient_d;
              div_by_zero_q <= spec_dbz_d;
              invalid_q     <= spec_inv_d;
              out_valid_q   <= 1'b1;
              state_q       <= DONE;
            end else begin
              dp_load_q     <= 1'b1;
              state_q       <= LOAD;
            end
          end
        end
        LOAD: begin
          dp_load_q    <= 1'b0;
          cnt_q        <= '0;
          dp_iter_en_q <= 1'b1;
          state_q      <= ITER;
        end
        ITER: begin
          if (cnt_q == LAST_CNT) begin
            dp_iter_en_q <= 1'b0;
            state_q      <= POST;
          end else begin
            cnt_q        <= cnt_q + CNT_ONE;
          end
        end
        POST: begin
          quotient_q    <= dp_quotient;
          div_by_zero_q <= 1'b0;
          invalid_q     <= 1'b0;
          out_valid_q   <= 1'b1;
          state_q       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign dp_dividend = dp_dividend_q;
  assign dp_divisor  = dp_divisor_q;
  assign dp_load     = dp_load_q;
  assign dp_iter_en  = dp_iter_en_q;
  assign quotient    = quotient_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = div_by_zero_q;
  assign invalid     = invalid_q;

endmodule

// File: tb/tb_srt_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_srt_div_sequencer
//
// Scoreboard bench for srt_div_sequencer. The stimulus process pushes the
// hand-computed expected response of each operand pair into a queue; an
// independent monitor pops and compares whenever the DUT presents a result.
// A tiny datapath stand-in only yields the real quotient after exactly 13
// iteration strobes following a load, so a wrong step count is visible.
// ---------------------------------------------------------------------------
module tb_srt_div_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] dp_dividend;
  logic [31:0] dp_divisor;
  logic        dp_load;
  logic        dp_iter_en;
  logic [31:0] dp_quotient;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        div_by_zero;
  logic        invalid;
  logic        busy;

  typedef struct {
    logic [31:0] quot;
    logic        dbz;
    logic        inv;
    int          lat;
    int          loads;
    int          iters;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleNum = 0;
  int   modelIters;
  logic spacingArmed;

  srt_div_sequencer #(
    .ITERATIONS(13),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .dp_dividend(dp_dividend),
    .dp_divisor(dp_divisor),
    .dp_load(dp_load),
    .dp_iter_en(dp_iter_en),
    .dp_quotient(dp_quotient),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .div_by_zero(div_by_zero),
    .invalid(invalid),
    .busy(busy)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure latencies and issue spacing
  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Datapath stand-in: known operand pairs give their quotient, but only
  // once exactly 13 steps have been performed since the last load
  function automatic logic [31:0] modelQuot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40C00000_40000000: return 32'h40400000;
      64'h3F800000_40800000: return 32'h3E800000;
      64'h41400000_C0800000: return 32'hC0400000;
      64'h00000001_40000000: return 32'h00000000;
      default:               return 32'hBAD0BAD0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)             modelIters <= 0;
    else if (dp_load)    modelIters <= 0;
    else if (dp_iter_en) modelIters <= modelIters + 1;
  end

  assign dp_quotient = (modelIters == 13) ? modelQuot(dp_dividend, dp_divisor) : 32'hBAD0BAD0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting", name);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " dp_dividend"}, dp_dividend, 32'h0);
    checkOutput({tag, " dp_divisor"}, dp_divisor, 32'h0);
    checkOutput({tag, " dp_load"}, 32'(dp_load), 32'h0);
    checkOutput({tag, " dp_iter_en"}, 32'(dp_iter_en), 32'h0);
    checkOutput({tag, " quotient"}, quotient, 32'h0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, " div_by_zero"}, 32'(div_by_zero), 32'h0);
    checkOutput({tag, " invalid"}, 32'(invalid), 32'h0);
    checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'h1);
  endtask

  // Push the expectation, then hold the pair on the bus until accepted.
  // Entered and left just after a rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] q, input logic dbz, input logic inv,
                               input int lat, input int loads, input int iters);
    exp_t e;
    logic sawReady;
    logic accepted;
    e.quot = q; e.dbz = dbz; e.inv = inv;
    e.lat = lat; e.loads = loads; e.iters = iters;
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      sawReady = in_ready;
      @(posedge clk);
      #1;
      if (sawReady) accepted = 1'b1;
    end
    in_valid = 1'b0;
    if (!accepted) failTimeout("acceptance");
  endtask

  task automatic waitIdle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      if (sb.size() == 0 && in_ready && !out_valid) idle = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!idle) failTimeout("return to idle");
  endtask

  // Monitor state
  logic        prevOut;
  logic        expectIdleNext;
  logic        haveCur;
  logic        havePrevAccept;
  int          loadCnt;
  int          iterCnt;
  int          acceptCycle;
  int          lastAccept;
  logic [31:0] heldQ;
  logic        heldD;
  logic        heldI;
  exp_t        cur;

  // Monitor: runs on the falling edge, counts strobes since acceptance,
  // compares each presented result with the scoreboard head, watches for
  // stability while back-pressured and for the return to idle afterwards.
  initial begin
    prevOut = 1'b0; expectIdleNext = 1'b0; haveCur = 1'b0; havePrevAccept = 1'b0;
    loadCnt = 0; iterCnt = 0; acceptCycle = 0; lastAccept = 0;
    heldQ = 32'h0; heldD = 1'b0; heldI = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevOut = 1'b0; expectIdleNext = 1'b0; haveCur = 1'b0;
        havePrevAccept = 1'b0; loadCnt = 0; iterCnt = 0;
      end else begin
        if (expectIdleNext) begin
          checkOutput("out_valid drop after handshake", 32'(out_valid), 32'h0);
          checkOutput("in_ready after handshake", 32'(in_ready), 32'h1);
          expectIdleNext = 1'b0;
        end
        if (dp_load)    loadCnt++;
        if (dp_iter_en) iterCnt++;
        if (out_valid && !prevOut) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected out_valid: got quotient 0x%08h expected no result", quotient);
            haveCur = 1'b0;
          end else begin
            cur = sb[0];
            haveCur = 1'b1;
            checkOutput("latency", 32'(cycleNum - acceptCycle + 1), 32'(cur.lat));
            checkOutput("dp_load pulses", 32'(loadCnt), 32'(cur.loads));
            checkOutput("dp_iter_en pulses", 32'(iterCnt), 32'(cur.iters));
            checkOutput("quotient", quotient, cur.quot);
            checkOutput("div_by_zero", 32'(div_by_zero), 32'(cur.dbz));
            checkOutput("invalid", 32'(invalid), 32'(cur.inv));
            heldQ = quotient;
            heldD = div_by_zero;
            heldI = invalid;
          end
        end else if (out_valid && haveCur) begin
          checkOutput("held quotient", quotient, heldQ);
          checkOutput("held div_by_zero", 32'(div_by_zero), 32'(heldD));
          checkOutput("held invalid", 32'(invalid), 32'(heldI));
          checkOutput("in_ready while done", 32'(in_ready), 32'h0);
        end
        if (out_valid && out_ready && haveCur) begin
          void'(sb.pop_front());
          haveCur = 1'b0;
          expectIdleNext = 1'b1;
        end
        if (in_valid && in_ready) begin
          if (spacingArmed) begin
            if (havePrevAccept)
              checkOutput("issue spacing", 32'(cycleNum + 1 - lastAccept), 32'd17);
            havePrevAccept = 1'b1;
            lastAccept = cycleNum + 1;
          end else begin
            havePrevAccept = 1'b0;
          end
          acceptCycle = cycleNum + 1;
          loadCnt = 0;
          iterCnt = 0;
        end
        prevOut = out_valid;
      end
    end
  end

  // Watchdog so a stuck DUT still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    int   iterSeen;
    logic seenValid;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    dividend = 32'h0;
    divisor = 32'h0;
    spacingArmed = 1'b0;

    #3;
    checkResetOutputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] normal divide 6.0/2.0");
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 16, 1, 13);
    waitIdle();

    $display("[TB] special cases");
    applyStimulus(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1, 0, 0);
    applyStimulus(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1, 0, 0);
    applyStimulus(32'h80000000, 32'h40400000, 32'h80000000, 1'b0, 1'b0, 1, 0, 0);
    applyStimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 1, 0, 0);
    applyStimulus(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 1, 0, 0);
    applyStimulus(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1, 0, 0);
    applyStimulus(32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1, 0, 0);
    applyStimulus(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 1, 0, 0);
    applyStimulus(32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1, 0, 0);
    waitIdle();

    $display("[TB] subnormal dividend goes to datapath");
    applyStimulus(32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 16, 1, 13);
    waitIdle();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h3F800000, 32'h40800000, 32'h3E800000, 1'b0, 1'b0, 16, 1, 13);
    seenValid = 1'b0;
    for (int i = 0; i < 40 && !seenValid; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seenValid = 1'b1;
    end
    if (!seenValid) failTimeout("out_valid under backpressure");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      dividend = 32'h12345678 + i;
      divisor  = 32'h40C00000 + i;
    end
    checkOutput("dp_dividend held", dp_dividend, 32'h3F800000);
    checkOutput("dp_divisor held", dp_divisor, 32'h40800000);
    checkOutput("out_valid held", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitIdle();

    $display("[TB] reset in the middle of iterations");
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 16, 1, 13);
    iterSeen = 0;
    for (int i = 0; i < 40 && iterSeen < 6; i++) begin
      @(posedge clk);
      #1;
      if (dp_iter_en) iterSeen++;
    end
    if (iterSeen != 6) failTimeout("iteration count before reset");
    rst = 1'b1;
    sb.delete();
    #1;
    checkResetOutputs("mid-iter reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("in_ready after release", 32'(in_ready), 32'h1);
    repeat (20) @(posedge clk);
    #1;
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 16, 1, 13);
    waitIdle();

    $display("[TB] back-to-back divides");
    spacingArmed = 1'b1;
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 16, 1, 13);
    applyStimulus(32'h3F800000, 32'h40800000, 32'h3E800000, 1'b0, 1'b0, 16, 1, 13);
    applyStimulus(32'h41400000, 32'hC0800000, 32'hC0400000, 1'b0, 1'b0, 16, 1, 13);
    waitIdle();
    spacingArmed = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
